// File: rtl/mem_bist_master.sv
// March self-test initiator for the data memory: W0, R0, W1 (inverted), R1, then pass/fail report.
// Latency: 4*WORDS+3 cycles from the start edge to the done pulse; read data is expected 1 cycle after a read request.
// Backpressure: none; one request per cycle, and start is ignored while a run is in progress.
module mem_bist_master #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                WORDS     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 4,
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(32'hA5A5_0000),
  parameter int                ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_RD0, S_CHK0, S_WR1, S_RD1, S_CHK1, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_idx;
  logic                inv;
  logic                start_run;
  logic [DATA_W-1:0]   pat;

  // Compare pipeline: expectation captured with each read request, checked one cycle later.
  logic                cmp_vld_q;
  logic [DATA_W-1:0]   exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;
  logic                mismatch;

  logic [ERR_W-1:0]    err_q, err_next;
  logic [ADDR_W-1:0]   ffa_q;
  logic                pass_q;

  assign last_idx  = (idx_q == IDX_W'(WORDS - 1));
  assign start_run = (state_q == S_IDLE) && start;
  assign inv       = (state_q == S_WR1) || (state_q == S_RD1);
  assign pat       = inv ? ~(SEED + DATA_W'(idx_q)) : (SEED + DATA_W'(idx_q));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_en  = 1'b0;
    mem_wr  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR0;
          idx_d   = '0;
        end
      end
      S_WR0, S_WR1: begin
        mem_en = 1'b1;
        mem_wr = 1'b1;
        busy   = 1'b1;
        idx_d  = last_idx ? '0 : idx_q + IDX_W'(1);
        if (last_idx) state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
      end
      S_RD0, S_RD1: begin
        mem_en = 1'b1;
        busy   = 1'b1;
        idx_d  = last_idx ? '0 : idx_q + IDX_W'(1);
        if (last_idx) state_d = (state_q == S_RD0) ? S_CHK0 : S_CHK1;
      end
      S_CHK0: begin
        busy    = 1'b1;
        state_d = S_WR1;
      end
      S_CHK1: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = mem_en ? (BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP)) : '0;
  assign mem_wdata = (mem_en && mem_wr) ? pat : '0;

  assign mismatch = cmp_vld_q && (mem_rdata != exp_q);
  assign err_next = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cmp_vld_q  <= 1'b0;
      exp_q      <= '0;
      cmp_addr_q <= '0;
      err_q      <= '0;
      ffa_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmp_vld_q <= mem_en && !mem_wr;
      if (mem_en && !mem_wr) begin
        exp_q      <= pat;
        cmp_addr_q <= mem_addr;
      end
      if (start_run) begin
        err_q  <= '0;
        ffa_q  <= '0;
        pass_q <= 1'b0;
      end else begin
        err_q <= err_next;
        // err_q never returns to zero within a run, so zero means no earlier mismatch.
        if (mismatch && (err_q == '0)) ffa_q <= cmp_addr_q;
        if (state_q == S_CHK1) pass_q <= (err_next == '0);
      end
    end
  end

  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
  assign pass            = pass_q;

endmodule
